stage_chi: RTL and testbench

STAGE_CHI -- requirements
Module: stage_chi

---
 rtl/keccak_pkg.sv | 20 ++
 rtl/chi_row.sv | 15 +
 rtl/stage_chi.sv | 129 ++++++++++++
 tb/tb_stage_chi.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak-f constants and state-bus helpers for the permutation stages.
// Lane (x,y) bit z of the packed state sits at bit W*(5*x+y)+z.
package keccak_pkg;

    localparam int W       = 64;
    localparam int NROUNDS = 24;
    localparam int STATE_W = 25 * W;

    // Sideband carried alongside the state through a stage
    typedef struct packed {
        logic [7:0] r;
        logic [4:0] rnd;
        logic       last;
    } beat_meta_t;

    function automatic int lane_idx(input int w, input int x, input int y, input int z);
        return w * (5 * x + y) + z;
    endfunction

endpackage

// File: rtl/chi_row.sv
// Chi nonlinearity on one 5-bit row: b[x] = a[x] ^ (~a[x+1] & a[x+2]), indices mod 5.
module chi_row (
    input  logic [4:0] row_i,
    output logic [4:0] row_o
);

    // Purely combinational row mix
    always_comb begin
        row_o = 5'b00000;
        for (int x = 0; x < 5; x++) begin
            row_o[x] = row_i[x] ^ (~row_i[(x + 1) % 5] & row_i[(x + 2) % 5]);
        end
    end

endmodule

// File: rtl/stage_chi.sv
// Keccak chi pipeline stage: combinational chi on the incoming state, then a
// two-entry (main + skid) output buffer with a registered in_ready.
module stage_chi #(
    parameter int W       = keccak_pkg::W,
    parameter int NROUNDS = keccak_pkg::NROUNDS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [25*W-1:0] din,
    input  logic [7:0]      in_r,
    input  logic [4:0]      in_rnd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [25*W-1:0] dout,
    output logic [7:0]      out_r,
    output logic [4:0]      out_rnd,
    output logic            out_last,
    output logic            err
);

    import keccak_pkg::*;

    localparam int         SW       = 25 * W;
    localparam logic [5:0] NR_W     = 6'(NROUNDS);
    localparam logic [4:0] LAST_RND = 5'(NROUNDS - 1);

    logic [SW-1:0] chi_s;

    for (genvar y = 0; y < 5; y++) begin : g_y
        for (genvar z = 0; z < W; z++) begin : g_z
            logic [4:0] row_in_s;
            logic [4:0] row_out_s;
            for (genvar x = 0; x < 5; x++) begin : g_x
                assign row_in_s[x] = din[lane_idx(W, x, y, z)];
                assign chi_s[lane_idx(W, x, y, z)] = row_out_s[x];
            end
            chi_row u_row (
                .row_i (row_in_s),
                .row_o (row_out_s)
            );
        end
    end

    logic          main_valid_q, main_valid_d;
    logic [SW-1:0] main_data_q,  main_data_d;
    beat_meta_t    main_meta_q,  main_meta_d;
    logic          skid_valid_q, skid_valid_d;
    logic [SW-1:0] skid_data_q,  skid_data_d;
    beat_meta_t    skid_meta_q,  skid_meta_d;
    logic          in_ready_q,   in_ready_d;
    logic          err_q,        err_d;

    logic       accept_s;
    logic       legal_s;
    logic       store_s;
    logic       deliver_s;
    beat_meta_t new_meta_s;

    // Illegal round indices are consumed but never stored
    assign accept_s   = in_valid & in_ready_q;
    assign legal_s    = ({1'b0, in_rnd} < NR_W);
    assign store_s    = accept_s & legal_s;
    assign deliver_s  = main_valid_q & out_ready;
    assign new_meta_s = '{r: in_r, rnd: in_rnd, last: (in_rnd == LAST_RND)};

    // Next-state for the main/skid buffer, ready and sticky error
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_meta_d  = main_meta_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_meta_d  = skid_meta_q;
        if (!main_valid_q || deliver_s) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_meta_d  = skid_meta_q;
                skid_valid_d = store_s;
                skid_data_d  = store_s ? chi_s : skid_data_q;
                skid_meta_d  = store_s ? new_meta_s : skid_meta_q;
            end else begin
                main_valid_d = store_s;
                main_data_d  = store_s ? chi_s : main_data_q;
                main_meta_d  = store_s ? new_meta_s : main_meta_q;
            end
        end else begin
            skid_valid_d = skid_valid_q | store_s;
            skid_data_d  = store_s ? chi_s : skid_data_q;
            skid_meta_d  = store_s ? new_meta_s : skid_meta_q;
        end
        in_ready_d = ~skid_valid_d;
        err_d      = err_q | (accept_s & ~legal_s);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_meta_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_meta_q  <= '0;
            in_ready_q   <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_meta_q  <= main_meta_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_meta_q  <= skid_meta_d;
            in_ready_q   <= in_ready_d;
            err_q        <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign dout      = main_data_q;
    assign out_r     = main_meta_q.r;
    assign out_rnd   = main_meta_q.rnd;
    assign out_last  = main_meta_q.last;
    assign err       = err_q;

endmodule

// File: tb/tb_stage_chi.sv
// Self-checking bench for stage_chi: directed scenarios plus random traffic
// checked against a lane-level chi model and a FIFO-of-beats reference.
module tb_stage_chi;

    localparam int W  = 64;
    localparam int NR = 24;
    localparam int SW = 25 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] din;
    logic [7:0]    in_r;
    logic [4:0]    in_rnd;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] dout;
    logic [7:0]    out_r;
    logic [4:0]    out_rnd;
    logic          out_last;
    logic          err;

    stage_chi #(.W(W), .NROUNDS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .in_r      (in_r),
        .in_rnd    (in_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_r     (out_r),
        .out_rnd   (out_rnd),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] d;
        logic [7:0]    r;
        logic [4:0]    rnd;
    } beat_t;

    beat_t mq[$];
    int    dlv_rnd[$];
    logic  m_ready;
    logic  m_err;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] ref_chi(input logic [SW-1:0] s);
        logic [W-1:0]  a[5][5];
        logic [SW-1:0] o;
        o = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                a[x][y] = s[W*(5*x+y) +: W];
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                o[W*(5*x+y) +: W] = a[x][y] ^ (~a[(x+1)%5][y] & a[(x+2)%5][y]);
        return o;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] s;
        for (int i = 0; i < SW / 32; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic check_state();
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("err", 64'(err), 64'(m_err));
        if (mq.size() != 0) begin
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    chk($sformatf("dout[%0d][%0d]", x, y), dout[W*(5*x+y) +: W],
                        mq[0].d[W*(5*x+y) +: W]);
            chk("out_r", 64'(out_r), 64'(mq[0].r));
            chk("out_rnd", 64'(out_rnd), 64'(mq[0].rnd));
            chk("out_last", 64'(out_last), 64'(mq[0].rnd == 5'(NR - 1)));
        end
    endtask

    // One clock: drive inputs, advance, update the reference, compare
    task automatic step(input logic iv, input logic [SW-1:0] d, input logic [7:0] r,
                        input logic [4:0] rnd, input logic ordy, input logic rs);
        logic  acc;
        logic  dlv;
        beat_t b;
        in_valid  = iv;
        din       = d;
        in_r      = r;
        in_rnd    = rnd;
        out_ready = ordy;
        rst       = rs;
        acc = iv && m_ready && !rs;
        dlv = (mq.size() != 0) && ordy && !rs;
        if (dlv) dlv_rnd.push_back(int'(out_rnd));
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            if (dlv) void'(mq.pop_front());
            if (acc && (int'(rnd) < NR)) begin
                b.d   = ref_chi(d);
                b.r   = r;
                b.rnd = rnd;
                mq.push_back(b);
            end
            if (acc && (int'(rnd) >= NR)) m_err = 1'b1;
        end
        m_ready = (mq.size() < 2);
        check_state();
    endtask

    logic [SW-1:0] zs;
    logic [SW-1:0] s34;
    logic [SW-1:0] e34;
    logic [SW-1:0] d7;

    initial begin
        zs        = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        in_r      = 8'h00;
        in_rnd    = 5'd0;
        out_ready = 1'b0;
        m_ready   = 1'b1;
        m_err     = 1'b0;

        step(1'b1, rand_state(), 8'h5a, 5'd3, 1'b1, 1'b1);
        step(1'b0, zs, 8'h00, 5'd0, 1'b1, 1'b1);
        chk("rst_dout_nz", 64'(|dout), 64'd0);
        chk("rst_out_r", 64'(out_r), 64'd0);
        chk("rst_out_rnd", 64'(out_rnd), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);

        // All-zero state, first round
        step(1'b1, zs, 8'h01, 5'd0, 1'b1, 1'b0);
        chk("t33_valid", 64'(out_valid), 64'd1);
        chk("t33_dout_nz", 64'(|dout), 64'd0);
        chk("t33_out_r", 64'(out_r), 64'h01);
        chk("t33_last", 64'(out_last), 64'd0);
        step(1'b0, zs, 8'h00, 5'd0, 1'b1, 1'b0);

        // Single all-ones lane (2,0)
        s34 = '0;
        s34[W*10 +: W] = '1;
        e34 = '0;
        e34[0 +: W]    = '1;
        e34[W*10 +: W] = '1;
        step(1'b1, s34, 8'h02, 5'd1, 1'b1, 1'b0);
        chk("t34_dout", 64'(dout === e34), 64'd1);
        step(1'b0, zs, 8'h00, 5'd0, 1'b1, 1'b0);

        // Backpressure fills main and skid, then drains in order
        dlv_rnd.delete();
        d7 = rand_state();
        step(1'b1, rand_state(), 8'h11, 5'd5, 1'b0, 1'b0);
        step(1'b1, rand_state(), 8'h12, 5'd6, 1'b0, 1'b0);
        chk("t35_rdy_low", 64'(in_ready), 64'd0);
        step(1'b1, d7, 8'h13, 5'd7, 1'b0, 1'b0);
        chk("t35_hold", 64'(out_rnd), 64'd5);
        step(1'b1, d7, 8'h13, 5'd7, 1'b1, 1'b0);
        chk("t35_rdy_up", 64'(in_ready), 64'd1);
        step(1'b1, d7, 8'h13, 5'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, zs, 8'h00, 5'd0, 1'b1, 1'b0);
        chk("t35_count", 64'(dlv_rnd.size()), 64'd3);
        for (int i = 0; i < 3 && i < dlv_rnd.size(); i++)
            chk($sformatf("t35_order%0d", i), 64'(dlv_rnd[i]), 64'(5 + i));

        // Last round flag and illegal round index
        step(1'b1, rand_state(), 8'h21, 5'd23, 1'b1, 1'b0);
        chk("t36_last", 64'(out_last), 64'd1);
        step(1'b1, rand_state(), 8'h22, 5'd24, 1'b1, 1'b0);
        chk("t36_err", 64'(err), 64'd1);
        chk("t36_nobeat", 64'(out_valid), 64'd0);
        step(1'b0, zs, 8'h00, 5'd0, 1'b1, 1'b0);
        step(1'b0, zs, 8'h00, 5'd0, 1'b1, 1'b0);
        chk("t36_sticky", 64'(err), 64'd1);

        // Reset while two beats are held
        step(1'b1, rand_state(), 8'h31, 5'd3, 1'b0, 1'b0);
        step(1'b1, rand_state(), 8'h32, 5'd4, 1'b0, 1'b0);
        step(1'b1, rand_state(), 8'h33, 5'd5, 1'b0, 1'b1);
        chk("t37_valid", 64'(out_valid), 64'd0);
        chk("t37_ready", 64'(in_ready), 64'd1);
        chk("t37_err", 64'(err), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, zs, 8'h00, 5'd0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [4:0] rn;
            rn = ($urandom_range(0, 9) == 0) ? 5'(24 + $urandom_range(0, 7))
                                             : 5'($urandom_range(0, 23));
            step(1'($urandom_range(0, 3) != 0), rand_state(), 8'($urandom),
                 rn, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, zs, 8'h00, 5'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
